// File: rtl/pipeline_stage_reg_if.sv
// rtl/pipeline_stage_reg_if.sv - valid/ready entry bus between pipeline stages
interface pipeline_stage_reg_if #(
   parameter int DATA_BITS    = 32,
   parameter int NUM_OPERANDS = 2,
   parameter int CTRL_BITS    = 8,
   parameter int META_BITS    = 9
);
   logic                              valid;
   logic                              ready;
   logic [DATA_BITS-1:0]              pc;
   logic [NUM_OPERANDS*DATA_BITS-1:0] operands;
   logic [DATA_BITS-1:0]              imm;
   logic [CTRL_BITS-1:0]              ctrl;
   logic [META_BITS-1:0]              meta;

   // producer side: drives the entry, observes ready
   modport master (
      output valid,
      output pc,
      output operands,
      output imm,
      output ctrl,
      output meta,
      input  ready
   );

   // consumer side: observes the entry, drives ready
   modport slave (
      input  valid,
      input  pc,
      input  operands,
      input  imm,
      input  ctrl,
      input  meta,
      output ready
   );
endinterface

// File: rtl/pipeline_stage_reg.sv
// rtl/pipeline_stage_reg.sv - inter-stage pipeline register with skid buffer, flush and perf counters
module pipeline_stage_reg #(
   parameter int DATA_BITS    = 32,
   parameter int NUM_OPERANDS = 2,
   parameter int CTRL_BITS    = 8,
   parameter int META_BITS    = 9,
   parameter int CNT_BITS     = 16
) (
   input  logic                clk,
   input  logic                n_reset,
   input  logic                flush,
   pipeline_stage_reg_if.slave  in_if,
   pipeline_stage_reg_if.master out_if,
   output logic [CNT_BITS-1:0] stall_count,
   output logic [CNT_BITS-1:0] bubble_count
);

   localparam int OPS_BITS = NUM_OPERANDS * DATA_BITS;

   typedef struct packed {
      logic [DATA_BITS-1:0] pc;
      logic [OPS_BITS-1:0]  operands;
      logic [DATA_BITS-1:0] imm;
      logic [CTRL_BITS-1:0] ctrl;
      logic [META_BITS-1:0] meta;
   } entry_t;

   localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};
   localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic [CNT_BITS-1:0] stall_q, stall_d;
   logic [CNT_BITS-1:0] bubble_q, bubble_d;

   entry_t in_entry;
   logic   accept;
   logic   advance;

   // ready depends only on registered skid state, so out_ready never reaches in_ready combinationally
   always_comb begin
      in_entry          = '0;
      in_entry.pc       = in_if.pc;
      in_entry.operands = in_if.operands;
      in_entry.imm      = in_if.imm;
      in_entry.ctrl     = in_if.ctrl;
      in_entry.meta     = in_if.meta;
      in_if.ready       = !skid_valid_q;
      accept            = in_if.valid && !skid_valid_q;
      advance           = out_if.ready || !main_valid_q;
   end

   // next entry state: flush kills both slots, otherwise main drains skid first to keep order
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (advance) begin
         if (skid_valid_q) begin
            // accept is impossible here since in_ready is low while skid is full
            main_d       = skid_q;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         // main is held by downstream, park the new entry in the skid slot
         skid_d       = in_entry;
         skid_valid_d = 1'b1;
      end
   end

   // saturating perf counters, each cycle classified from the current output state
   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (main_valid_q && !out_if.ready && (stall_q != CNT_MAX)) begin
         stall_d = stall_q + CNT_ONE;
      end
      if (!main_valid_q && (bubble_q != CNT_MAX)) begin
         bubble_d = bubble_q + CNT_ONE;
      end
   end

   // state registers; reset takes priority over flush and clears data as well as valids
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
         stall_q      <= '0;
         bubble_q     <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         stall_q      <= stall_d;
         bubble_q     <= bubble_d;
      end
   end

   // a bubble presents NOP control downstream; the rest of the data just holds
   always_comb begin
      out_if.valid    = main_valid_q;
      out_if.pc       = main_q.pc;
      out_if.operands = main_q.operands;
      out_if.imm      = main_q.imm;
      out_if.meta     = main_q.meta;
      out_if.ctrl     = main_valid_q ? main_q.ctrl : '0;
      stall_count     = stall_q;
      bubble_count    = bubble_q;
   end

endmodule
